// File: rtl/inner_product_mac_unit.sv
// Handshaked inner-product MAC: LANES products per cycle over SIZE/LANES beats,
// run-time loadable weights, exact accumulation and saturate/wrap output formatting.
module inner_product_mac_unit #(
    parameter int SIZE     = 9,
    parameter int D_WIDTH  = 8,
    parameter int Q_WIDTH  = 20,
    parameter int LANES    = 3,
    parameter bit SATURATE = 1'b1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     w_wr_en,
    input  logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] w_wr_addr,
    input  logic [D_WIDTH-1:0]                       w_wr_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [D_WIDTH*SIZE-1:0]                  input_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [Q_WIDTH-1:0]                       output_data,
    output logic                                     overflow
);

    localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int BEATS = SIZE / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ACC_W = 2*D_WIDTH + $clog2(SIZE) + 1;
    localparam int WW    = (ACC_W > Q_WIDTH) ? ACC_W : Q_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t                    state_q, state_d;
    logic [D_WIDTH*SIZE-1:0]   vec_q, vec_d;
    logic [D_WIDTH*SIZE-1:0]   wgt_q, wgt_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [Q_WIDTH-1:0]        out_q, out_d;
    logic                      ovf_q, ovf_d;

    logic [ACC_W-1:0]          laneSum;
    logic [ACC_W-1:0]          sumNext;
    logic [WW-1:0]             sumWide;
    logic                      sumOvf;
    logic [Q_WIDTH-1:0]        sumFmt;

    // Sum of this beat's LANES full-precision products.
    always_comb begin
        laneSum = '0;
        for (int l = 0; l < LANES; l++) begin
            laneSum = laneSum + ACC_W'(
                {{D_WIDTH{1'b0}}, vec_q[(int'(beat_q)*LANES + l)*D_WIDTH +: D_WIDTH]} *
                {{D_WIDTH{1'b0}}, wgt_q[(int'(beat_q)*LANES + l)*D_WIDTH +: D_WIDTH]});
        end
    end

    // The exact sum is widened so the overflow compare also works when Q_WIDTH >= ACC_W.
    always_comb begin
        sumNext = acc_q + laneSum;
        sumWide = WW'(sumNext);
        sumOvf  = sumWide > {{(WW-Q_WIDTH){1'b0}}, {Q_WIDTH{1'b1}}};
        sumFmt  = (SATURATE && sumOvf) ? {Q_WIDTH{1'b1}} : sumWide[Q_WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        wgt_d     = wgt_q;
        acc_d     = acc_q;
        beat_d    = beat_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (w_wr_en && ({1'b0, w_wr_addr} < (AW+1)'(SIZE))) begin
                    wgt_d[int'(w_wr_addr)*D_WIDTH +: D_WIDTH] = w_wr_data;
                end
            end
            ACCUM: begin
                acc_d  = sumNext;
                beat_d = beat_q + 1'b1;
                if (beat_q == BW'(BEATS-1)) begin
                    state_d = HOLD;
                    out_d   = sumFmt;
                    ovf_d   = sumOvf;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accept in HOLD overrides the return to IDLE for back-to-back vectors.
        if (in_valid && in_ready) begin
            vec_d   = input_data;
            acc_d   = '0;
            beat_d  = '0;
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            wgt_q   <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wgt_q   <= wgt_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign output_data = out_q;
    assign overflow    = ovf_q;

endmodule
